rps_match_engine: RTL
=====================

# rps_match_engine

Parametrised multi-round stone-paper-scissors match controller. It latches two players' moves on a debounced rising edge of `start`, judges each round, and keeps per-player scores and a round count. It declares a match winner at a configurable win threshold or round cap. It is the successor to the single-round game core and drives the same 8-bit status path plus wider score outputs.

## Interface
Parameters:
- `WINS_TO_MATCH`, default 3: round wins needed to take the match; must be ≥1 and < 2^`SCORE_W`.
- `MAX_ROUNDS`, default 9: round cap, counting ties but not invalid rounds; must be ≥ 2·`WINS_TO_MATCH`−1.
- `SCORE_W`, default 4: width of score counters.
- `ROUND_W`, default 4: width of the round counter; must satisfy 2^`ROUND_W` > `MAX_ROUNDS`.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: level from the player button; only the rising edge acts.
- `p1_move` input 3: player 1 gesture code.
- `p2_move` input 3: player 2 gesture code.
- `round_result` output 2: last round outcome. 00 = tie, 01 = P1 wins, 10 = P2 wins, 11 = invalid.
- `result_valid` output 1: one-cycle pulse when `round_result` updates.
- `p1_score` output `SCORE_W`: P1 round wins.
- `p2_score` output `SCORE_W`: P2 round wins.
- `round_count` output `ROUND_W`: valid rounds played.
- `match_over` output 1: high while in MATCH_OVER.
- `match_winner` output 2: 00 = draw/none, 01 = P1, 10 = P2; valid while `match_over` is high.
- `state` output 2: current FSM state code.

## Operation
- Gesture codes: 0 stone, 1 paper, 2 scissors; codes 3–7 are invalid (see Configuration).
- FSM states:
  - IDLE = 0
  - EVAL = 1
  - RESULT = 2
  - MATCH_OVER = 3
- Edge detect: `start_q` registers `start`. A rise is `start & ~start_q`.
- IDLE: on a rise, latch `p1_move` and `p2_move` into internal registers, then go to EVAL. Otherwise hold.
- EVAL, one cycle:
  - Judge the latched moves and write `round_result`. Pulse `result_valid`.
  - Invalid round: scores and `round_count` unchanged.
  - Tie: `round_count` +1.
  - Win: winner's score +1 and `round_count` +1.
  - Go to MATCH_OVER if a post-update score equals `WINS_TO_MATCH` or `round_count` equals `MAX_ROUNDS`. Otherwise go to RESULT.
- RESULT: wait for `start` low, then go to IDLE. Holding `start` never re-triggers a round.
- MATCH_OVER:
  - `match_winner` is the player who reached `WINS_TO_MATCH`.
  - At the round cap, it is the higher score, or 00 if scores are equal.
  - Outputs hold until a rise on `start`. That rise clears scores, `round_count`, `round_result`, and `match_winner`, then returns to IDLE. Moves presented on that rise are not latched.
- If the win threshold and the round cap are hit in the same EVAL, the threshold winner is reported.
- Counters never wrap; parameter constraints guarantee the cap is reached first.

## Timing
- Reset values:
  - `state` = IDLE.
  - All scores, `round_count`, `round_result`, `match_winner`, `result_valid`, and `match_over` = 0.
  - `start_q` = 1, so a button held through reset does not start a round.
- Latency: `start` rises in cycle T with the FSM in IDLE. State is EVAL in T+1. In T+2, `result_valid` = 1, and scores, `round_result`, and state (RESULT or MATCH_OVER) are updated.
- Moves are sampled only at the T→T+1 edge. Later move changes do not affect that round.
- `result_valid` is high for exactly one cycle per EVAL.
- A `reset` assertion in any state returns all outputs to reset values immediately, asynchronously, with no partial score update.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- Macro `RPS_LIZARD_SPOCK_EN`.
- Defined: codes 3 (lizard) and 4 (spock) are valid; codes 5–7 are invalid. Win rules:
  - stone beats scissors and lizard.
  - paper beats stone and spock.
  - scissors beats paper and lizard.
  - lizard beats paper and spock.
  - spock beats stone and scissors.
- Undefined: only codes 0–2 are valid, with classic rules; codes 3–7 are invalid.
- Port widths are identical in both builds.

## Structure
- Shared package `rps_pkg`:
  - Gesture code constants.
  - Result codes (TIE, P1, P2, INVALID).
  - Match-winner codes.
  - FSM state enum.
- Sub-module `rps_judge`: purely combinational. Inputs are two 3-bit moves; output is a 2-bit result. All `RPS_LIZARD_SPOCK_EN` conditionals live here.
- The top holds the FSM, edge detect, move latches, counters, and match logic.

## Test plan
- Reset with `start` held high, then hold it → FSM stays IDLE, no `result_valid`.
- `p1_move`=0, `p2_move`=2, pulse `start` → `result_valid` in cycle T+2, `round_result`=01, `p1_score`=1, `round_count`=1, state RESULT.
- `p1_move`=1, `p2_move`=1 → `round_result`=00, scores unchanged, `round_count` +1. `p1_move`=3, undefined macro → `round_result`=11, `round_count` unchanged.
- P2 wins three rounds (defaults) → `match_over`=1, `match_winner`=10. Next `start` rise → all counters 0, state IDLE.
- `MAX_ROUNDS`=5, `WINS_TO_MATCH`=3, rounds P1, P2, tie, P1, P2 → `match_over` after round 5, `match_winner`=00.
- With `RPS_LIZARD_SPOCK_EN`: `p1_move`=4, `p2_move`=2 → `round_result`=01. Assert `reset` during EVAL → all outputs 0 the same cycle.

Source files
------------

// File: rtl/rps_pkg.sv
// ----------------------------------------------------------------------------
// rps_pkg
// Shared definitions for the stone-paper-scissors match engine:
//   - gesture codes (classic set plus lizard/spock)
//   - round result codes and match-winner codes
//   - FSM state enumeration
// No ports; imported by rps_judge and rps_match_engine.
// ----------------------------------------------------------------------------
package rps_pkg;

    // Gesture codes
    localparam logic [2:0] MV_STONE    = 3'd0;
    localparam logic [2:0] MV_PAPER    = 3'd1;
    localparam logic [2:0] MV_SCISSORS = 3'd2;
    localparam logic [2:0] MV_LIZARD   = 3'd3;
    localparam logic [2:0] MV_SPOCK    = 3'd4;

    // Round result codes
    localparam logic [1:0] RES_TIE     = 2'b00;
    localparam logic [1:0] RES_P1      = 2'b01;
    localparam logic [1:0] RES_P2      = 2'b10;
    localparam logic [1:0] RES_INVALID = 2'b11;

    // Match winner codes
    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_P1   = 2'b01;
    localparam logic [1:0] MW_P2   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_EVAL       = 2'd1,
        ST_RESULT     = 2'd2,
        ST_MATCH_OVER = 2'd3
    } state_t;

endpackage

// File: rtl/rps_judge.sv
// ----------------------------------------------------------------------------
// rps_judge
// Purely combinational round judge.
// Optional feature macro: RPS_LIZARD_SPOCK_EN
//   defined   : codes 0-4 valid (stone, paper, scissors, lizard, spock)
//   undefined : codes 0-2 valid, classic rules
// Ports:
//   i_p1_move [2:0] : player 1 gesture code
//   i_p2_move [2:0] : player 2 gesture code
//   o_result  [1:0] : 00 tie, 01 P1 wins, 10 P2 wins, 11 invalid
// ----------------------------------------------------------------------------
module rps_judge
    import rps_pkg::*;
(
    input  logic [2:0] i_p1_move,
    input  logic [2:0] i_p2_move,
    output logic [1:0] o_result
);

    logic w_p1_valid;
    logic w_p2_valid;
    logic w_p1_beats;

    // True when gesture a defeats gesture b (both assumed valid and distinct)
    function automatic logic f_beats(input logic [2:0] a, input logic [2:0] b);
        logic r;
        r = 1'b0;
        case (a)
`ifdef RPS_LIZARD_SPOCK_EN
            MV_STONE:    r = (b == MV_SCISSORS) || (b == MV_LIZARD);
            MV_PAPER:    r = (b == MV_STONE)    || (b == MV_SPOCK);
            MV_SCISSORS: r = (b == MV_PAPER)    || (b == MV_LIZARD);
            MV_LIZARD:   r = (b == MV_PAPER)    || (b == MV_SPOCK);
            MV_SPOCK:    r = (b == MV_STONE)    || (b == MV_SCISSORS);
`else
            MV_STONE:    r = (b == MV_SCISSORS);
            MV_PAPER:    r = (b == MV_STONE);
            MV_SCISSORS: r = (b == MV_PAPER);
`endif
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

`ifdef RPS_LIZARD_SPOCK_EN
    assign w_p1_valid = (i_p1_move <= MV_SPOCK);
    assign w_p2_valid = (i_p2_move <= MV_SPOCK);
`else
    assign w_p1_valid = (i_p1_move <= MV_SCISSORS);
    assign w_p2_valid = (i_p2_move <= MV_SCISSORS);
`endif

    assign w_p1_beats = f_beats(i_p1_move, i_p2_move);

    always_comb begin
        if (!w_p1_valid || !w_p2_valid) begin
            o_result = RES_INVALID;
        end else if (i_p1_move == i_p2_move) begin
            o_result = RES_TIE;
        end else if (w_p1_beats) begin
            o_result = RES_P1;
        end else begin
            o_result = RES_P2;
        end
    end

endmodule

// File: rtl/rps_match_engine.sv
// ----------------------------------------------------------------------------
// rps_match_engine
// Multi-round stone-paper-scissors match controller. Latches both moves on a
// rising edge of start, judges the round, keeps scores and a round count and
// declares a match winner at WINS_TO_MATCH wins or after MAX_ROUNDS rounds.
// Optional feature macro: RPS_LIZARD_SPOCK_EN (handled inside rps_judge).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : player button level; only its rising edge acts
//   p1_move, p2_move    : 3-bit gesture codes
//   round_result [1:0]  : last round outcome (00 tie,01 P1,10 P2,11 invalid)
//   result_valid        : one-cycle pulse when round_result updates
//   p1_score, p2_score  : round wins per player (SCORE_W bits)
//   round_count         : valid rounds played (ROUND_W bits)
//   match_over          : high while in MATCH_OVER
//   match_winner [1:0]  : 00 draw/none, 01 P1, 10 P2
//   state [1:0]         : current FSM state code
// ----------------------------------------------------------------------------
module rps_match_engine
    import rps_pkg::*;
#(
    parameter int WINS_TO_MATCH = 3,
    parameter int MAX_ROUNDS    = 9,
    parameter int SCORE_W       = 4,
    parameter int ROUND_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         p1_move,
    input  logic [2:0]         p2_move,
    output logic [1:0]         round_result,
    output logic               result_valid,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [ROUND_W-1:0] round_count,
    output logic               match_over,
    output logic [1:0]         match_winner,
    output logic [1:0]         state
);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_start_q;
    logic               w_rise;
    logic [2:0]         r_p1_move;
    logic [2:0]         r_p2_move;
    logic [1:0]         w_judge;
    logic [1:0]         r_round_result;
    logic               r_result_valid;
    logic [SCORE_W-1:0] r_p1_score;
    logic [SCORE_W-1:0] r_p2_score;
    logic [ROUND_W-1:0] r_round_count;
    logic               r_match_over;
    logic [1:0]         r_match_winner;

    logic [SCORE_W-1:0] w_p1_score_nxt;
    logic [SCORE_W-1:0] w_p2_score_nxt;
    logic [ROUND_W-1:0] w_round_count_nxt;
    logic               w_hit_p1;
    logic               w_hit_p2;
    logic               w_match_end;
    logic [1:0]         w_winner_nxt;

    logic               w_do_latch;
    logic               w_do_eval;
    logic               w_do_clear;

    assign w_rise = start & ~r_start_q;

    rps_judge u_judge (
        .i_p1_move (r_p1_move),
        .i_p2_move (r_p2_move),
        .o_result  (w_judge)
    );

    // Post-update values of the counters for the round being judged
    assign w_p1_score_nxt    = r_p1_score + SCORE_W'(w_judge == RES_P1);
    assign w_p2_score_nxt    = r_p2_score + SCORE_W'(w_judge == RES_P2);
    assign w_round_count_nxt = r_round_count + ROUND_W'(w_judge != RES_INVALID);
    assign w_hit_p1          = (w_p1_score_nxt == SCORE_W'(WINS_TO_MATCH));
    assign w_hit_p2          = (w_p2_score_nxt == SCORE_W'(WINS_TO_MATCH));
    assign w_match_end       = w_hit_p1 || w_hit_p2 ||
                               (w_round_count_nxt == ROUND_W'(MAX_ROUNDS));

    // Threshold winner takes priority over the round-cap comparison
    always_comb begin
        if (w_hit_p1) begin
            w_winner_nxt = MW_P1;
        end else if (w_hit_p2) begin
            w_winner_nxt = MW_P2;
        end else if (w_p1_score_nxt > w_p2_score_nxt) begin
            w_winner_nxt = MW_P1;
        end else if (w_p2_score_nxt > w_p1_score_nxt) begin
            w_winner_nxt = MW_P2;
        end else begin
            w_winner_nxt = MW_NONE;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:       if (w_rise) w_next_state = ST_EVAL;
            ST_EVAL:       w_next_state = w_match_end ? ST_MATCH_OVER : ST_RESULT;
            ST_RESULT:     if (!start) w_next_state = ST_IDLE;
            ST_MATCH_OVER: if (w_rise) w_next_state = ST_IDLE;
            default:       w_next_state = ST_IDLE;
        endcase
    end

    // FSM: output/control decode feeding the registered datapath
    always_comb begin
        w_do_latch = 1'b0;
        w_do_eval  = 1'b0;
        w_do_clear = 1'b0;
        case (r_state)
            ST_IDLE:       w_do_latch = w_rise;
            ST_EVAL:       w_do_eval  = 1'b1;
            ST_MATCH_OVER: w_do_clear = w_rise;
            default:       ;
        endcase
    end

    // Registered datapath; every output comes straight from a flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_q      <= 1'b1;
            r_p1_move      <= '0;
            r_p2_move      <= '0;
            r_round_result <= RES_TIE;
            r_result_valid <= 1'b0;
            r_p1_score     <= '0;
            r_p2_score     <= '0;
            r_round_count  <= '0;
            r_match_over   <= 1'b0;
            r_match_winner <= MW_NONE;
        end else begin
            r_start_q      <= start;
            r_result_valid <= w_do_eval;
            r_match_over   <= (w_next_state == ST_MATCH_OVER);
            if (w_do_latch) begin
                r_p1_move <= p1_move;
                r_p2_move <= p2_move;
            end
            if (w_do_eval) begin
                r_round_result <= w_judge;
                r_p1_score     <= w_p1_score_nxt;
                r_p2_score     <= w_p2_score_nxt;
                r_round_count  <= w_round_count_nxt;
                if (w_match_end) begin
                    r_match_winner <= w_winner_nxt;
                end
            end
            if (w_do_clear) begin
                r_round_result <= RES_TIE;
                r_p1_score     <= '0;
                r_p2_score     <= '0;
                r_round_count  <= '0;
                r_match_winner <= MW_NONE;
            end
        end
    end

    assign round_result = r_round_result;
    assign result_valid = r_result_valid;
    assign p1_score     = r_p1_score;
    assign p2_score     = r_p2_score;
    assign round_count  = r_round_count;
    assign match_over   = r_match_over;
    assign match_winner = r_match_winner;
    assign state        = r_state;

endmodule
